// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operation encodings, FSM state type and default sizes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Default operand width and iteration counter width (2**CNT_W > WIDTH).
    localparam int c_def_width = 32;
    localparam int c_def_cnt_w = 6;

    // OpE encodings. Bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] c_op_mult  = 2'b00;
    localparam logic [1:0] c_op_multu = 2'b01;
    localparam logic [1:0] c_op_div   = 2'b10;
    localparam logic [1:0] c_op_divu  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Execute-stage request bundle between the pipeline and the
//               multiply/divide unit.
// Signals     : StartE, OpE, SrcAE, SrcBE, MtHiE, MtLoE  (pipeline -> unit)
//               BusyE, DoneM, Hi, Lo                     (unit -> pipeline)
// Modports    : master - pipeline side, slave - muldiv_unit side
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             StartE;
    logic [1:0]       OpE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             MtHiE;
    logic             MtLoE;
    logic             BusyE;
    logic             DoneM;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output StartE, OpE, SrcAE, SrcBE, MtHiE, MtLoE,
        input  BusyE, DoneM, Hi, Lo
    );

    modport slave (
        input  StartE, OpE, SrcAE, SrcBE, MtHiE, MtLoE,
        output BusyE, DoneM, Hi, Lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder, trial-subtracts the
//               divisor and keeps the difference when it does not underflow.
// Ports       : rem_in   - partial remainder (WIDTH)
//               dvd_bit  - next dividend bit, MSB first
//               divisor  - divisor magnitude (WIDTH)
//               rem_out  - next partial remainder (WIDTH)
//               q_bit    - quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;
    logic           w_unused_diff_msb;

    assign w_shifted = {rem_in, dvd_bit};
    assign w_diff    = w_shifted - {1'b0, divisor};
    assign q_bit     = (w_shifted >= {1'b0, divisor});

    // Once the divisor was subtracted the remainder is below the divisor and
    // fits WIDTH bits; when it was not, the shifted value is below the divisor
    // too (or the divisor is zero and only dividend bits were shifted in).
    assign rem_out   = q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

    assign w_unused_diff_msb = w_diff[WIDTH];
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Shift-add
//               multiply and restoring divide, one bit per cycle, followed by
//               a sign-fixup cycle. BusyE stalls the pipeline while running.
// Ports       : clk    - clock
//               rst_n  - synchronous active-low reset
//               mdif   - muldiv_if.slave (StartE, OpE, SrcAE, SrcBE, MtHiE,
//                        MtLoE in; BusyE, DoneM, Hi, Lo out)
// Config      : MULDIV_SIGNED_EN - when defined MULT/DIV are signed; when
//               undefined they behave as MULTU/DIVU and OpE[0] is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int CNT_W = c_def_cnt_w
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  mdif
);
    // Counter value at the last iteration; the increment on that edge brings
    // the count to WIDTH while the FSM moves to FIX.
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;     // {remainder/product-hi, quotient/product-lo}
    logic [WIDTH-1:0]   r_opb;     // multiplicand or divisor magnitude
    logic               r_is_div;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    // ------------------------------------------------------------------
    // Operand magnitudes and result-sign flags
    // ------------------------------------------------------------------
`ifdef MULDIV_SIGNED_EN
    logic r_neg_q;   // product / quotient is negative
    logic r_neg_r;   // remainder takes the dividend's (negative) sign
    logic w_sign_a;
    logic w_sign_b;

    assign w_sign_a = ~mdif.OpE[0] & mdif.SrcAE[WIDTH-1];
    assign w_sign_b = ~mdif.OpE[0] & mdif.SrcBE[WIDTH-1];
    // The most negative value negates to itself, which is its correct
    // unsigned magnitude.
    assign w_mag_a  = w_sign_a ? -mdif.SrcAE : mdif.SrcAE;
    assign w_mag_b  = w_sign_b ? -mdif.SrcBE : mdif.SrcBE;
`else
    logic w_unused_op0;

    assign w_mag_a      = mdif.SrcAE;
    assign w_mag_b      = mdif.SrcBE;
    assign w_unused_op0 = mdif.OpE[0];
`endif

    // ------------------------------------------------------------------
    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + {1'b0, (r_acc[0] ? r_opb : {WIDTH{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Divide step: the dividend sits in the lower half and is consumed MSB
    // first while quotient bits enter from the right.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_rem_next;
    logic               w_q_bit;
    logic [2*WIDTH-1:0] w_div_next;

    div_step #(
        .WIDTH   (WIDTH)
    ) u_div_step (
        .rem_in  (r_acc[2*WIDTH-1:WIDTH]),
        .dvd_bit (r_acc[WIDTH-1]),
        .divisor (r_opb),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

    assign w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_q_bit};

    // ------------------------------------------------------------------
    // Fixup: apply result signs
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

`ifdef MULDIV_SIGNED_EN
    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`else
    assign w_prod_fix = r_acc;
    assign w_quo_fix  = r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_acc[2*WIDTH-1:WIDTH];
`endif

    // ------------------------------------------------------------------
    // Control FSM and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mdif.StartE) begin
                        r_state  <= mdif.OpE[1] ? ST_DIV : ST_MUL;
                        r_is_div <= mdif.OpE[1];
                        r_cnt    <= '0;
                        r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                        r_opb    <= w_mag_b;
`ifdef MULDIV_SIGNED_EN
                        r_neg_q  <= w_sign_a ^ w_sign_b;
                        r_neg_r  <= w_sign_a;
`endif
                    end else begin
                        // MT writes only land when no operation is issued.
                        if (mdif.MtHiE) r_hi <= mdif.SrcAE;
                        if (mdif.MtLoE) r_lo <= mdif.SrcAE;
                    end
                end
                ST_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) r_state <= ST_FIX;
                end
                ST_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                    if (r_is_div) begin
                        r_lo <= w_quo_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        r_lo <= w_prod_fix[WIDTH-1:0];
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mdif.BusyE = (r_state != ST_IDLE);
    assign mdif.DoneM = r_done;
    assign mdif.Hi    = r_hi;
    assign mdif.Lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: table of directed
//               operations plus MT, reset and back-to-back sequences.
//               Expected values follow MULDIV_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdif  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive a start at the current negedge; return at the next negedge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.StartE = 1'b1;
        bus.OpE    = op;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        @(negedge clk);
        bus.StartE = 1'b0;
    endtask

    // Count busy negedges until idle (bounded); stops on the first idle one.
    task automatic wait_idle(output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.DoneM) done_n++;
            if (!bus.BusyE) break;
            busy_n++;
        end
    endtask

    initial begin
        int bn;
        int dn;
        int b1;

        checks = 0;
        errors = 0;

        vecs[0]  = '{c_op_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{c_op_divu,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[2]  = '{c_op_divu,  32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF};
        vecs[3]  = '{c_op_multu, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
        vecs[4]  = '{c_op_divu,  32'hFFFFFFFF, 32'h1,        32'h0,        32'hFFFFFFFF};
        vecs[5]  = '{c_op_mult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
`ifdef MULDIV_SIGNED_EN
        vecs[6]  = '{c_op_mult,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[7]  = '{c_op_div,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[8]  = '{c_op_div,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000};
        vecs[9]  = '{c_op_div,   32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'h00000001};
        vecs[10] = '{c_op_div,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
`else
        vecs[6]  = '{c_op_mult,  32'hFFFFFFF9, 32'd3,        32'h00000002, 32'hFFFFFFEB};
        vecs[7]  = '{c_op_div,   32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
        vecs[8]  = '{c_op_div,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0};
        vecs[9]  = '{c_op_div,   32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[10] = '{c_op_div,   32'd7,        32'hFFFFFFFE, 32'd7,        32'h0};
`endif

        bus.StartE = 1'b0;
        bus.OpE    = 2'b00;
        bus.SrcAE  = '0;
        bus.SrcBE  = '0;
        bus.MtHiE  = 1'b0;
        bus.MtLoE  = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("reset_busy", {31'b0, bus.BusyE}, 32'd0);
        chk("reset_done", {31'b0, bus.DoneM}, 32'd0);
        chk("reset_hi", bus.Hi, 32'd0);
        chk("reset_lo", bus.Lo, 32'd0);

        // Table of operations
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            b1 = int'(bus.BusyE);
            wait_idle(bn, dn);
            chk($sformatf("v%0d_busy_cycles", i), 32'(b1 + bn), 32'd33);
            chk($sformatf("v%0d_hi", i), bus.Hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), bus.Lo, vecs[i].lo);
            @(negedge clk);
            if (bus.DoneM) dn++;
            chk($sformatf("v%0d_done_pulses", i), 32'(dn), 32'd1);
        end

        // MT in idle: one-cycle latency
        bus.MtLoE = 1'b1;
        bus.SrcAE = 32'h0BADF00D;
        @(negedge clk);
        bus.MtLoE = 1'b0;
        chk("mtlo_idle", bus.Lo, 32'h0BADF00D);

        // StartE wins over a same-cycle MT write
        bus.MtLoE = 1'b1;
        issue(c_op_divu, 32'd100, 32'd7);
        bus.MtLoE = 1'b0;
        chk("prio_lo_kept", bus.Lo, 32'h0BADF00D);
        chk("prio_busy", {31'b0, bus.BusyE}, 32'd1);

        // MT while busy is ignored
        bus.MtLoE = 1'b1;
        bus.SrcAE = 32'hA5A5A5A5;
        @(negedge clk);
        bus.MtLoE = 1'b0;
        wait_idle(bn, dn);
        chk("mt_busy_lo", bus.Lo, 32'd14);
        chk("mt_busy_hi", bus.Hi, 32'd2);
        @(negedge clk);
        bus.MtHiE = 1'b1;
        bus.SrcAE = 32'h5A5A5A5A;
        @(negedge clk);
        bus.MtHiE = 1'b0;
        chk("mthi_after_done", bus.Hi, 32'h5A5A5A5A);
        chk("mthi_lo_kept", bus.Lo, 32'd14);

        // Back-to-back start in the DoneM cycle
        issue(c_op_divu, 32'd100, 32'd7);
        wait_idle(bn, dn);
        chk("b2b_first_done", {31'b0, bus.DoneM}, 32'd1);
        chk("b2b_first_lo", bus.Lo, 32'd14);
        issue(c_op_multu, 32'h12345678, 32'h10);
        chk("b2b_busy", {31'b0, bus.BusyE}, 32'd1);
        chk("b2b_done_low", {31'b0, bus.DoneM}, 32'd0);
        wait_idle(bn, dn);
        chk("b2b_busy_cycles", 32'(bn + 1), 32'd33);
        chk("b2b_hi", bus.Hi, 32'h00000001);
        chk("b2b_lo", bus.Lo, 32'h23456780);
        @(negedge clk);

        // Reset in the middle of a divide
        issue(c_op_div, 32'h00001234, 32'd3);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", {31'b0, bus.BusyE}, 32'd0);
        chk("midrst_done", {31'b0, bus.DoneM}, 32'd0);
        chk("midrst_hi", bus.Hi, 32'd0);
        chk("midrst_lo", bus.Lo, 32'd0);
        dn = 0;
        bn = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.DoneM) dn++;
            if (bus.BusyE) bn++;
        end
        chk("midrst_no_done", 32'(dn), 32'd0);
        chk("midrst_stays_idle", 32'(bn), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
